sc_ulpi_pktgen: RTL and testbench
=================================

Name: sc_ulpi_pktgen

Overview:
- Parametrised USB packet generator for the ULPI transmit path. Sits between the USB transaction layer and the ULPI protocol engine.
- Emits every transmittable USB packet type:
  - tokens OUT/IN/SETUP/PING/SOF, with CRC5;
  - DATA0/1/2/MDATA with a streamed payload of 0..MAX_PKT bytes and CRC16;
  - handshakes ACK/NAK/STALL/NYET, PID only.
- Adds abort, error reporting and payload back-pressure.

Parameters:
- MAX_PKT, 1024, maximum data payload in bytes; larger PKT_TX_NUM is rejected.
- LEN_W, 11, width of PKT_TX_NUM and the internal byte counter; requires 2**LEN_W > MAX_PKT.

Ports:
- ULPICLK  in  1  clock.
- ULPIRSTB  in  1  asynchronous active-low reset.
- PKT_TX_START  in  1  packet request; sampled in IDLE.
- PKT_TX_ABORT  in  1  abort the current packet.
- PKT_TX_COMP  out  1  one-cycle completion pulse.
- PKT_TX_ERR  out  1  valid with COMP; packet rejected or aborted.
- PKT_TX_PID  in  4  USB PID, 4-bit code.
- PKT_TX_ADR  in  7  device address.
- PKT_TX_EPN  in  4  endpoint number.
- PKT_TX_FMN  in  11  SOF frame number.
- PKT_TX_NUM  in  LEN_W  payload byte count.
- PKT_TX_DAT  in  8  payload byte.
- PKT_TX_DAT_VALID  in  1  payload byte valid.
- PKT_TX_DAT_READY  out  1  payload byte accepted this cycle.
- TXD_REQ  out  1  transmit request to the protocol engine.
- TXD_ACK  in  1  engine has finished the packet on ULPI.
- TXD_CPD  out  6  {2'b00, PID}.
- TXD_VALID  out  1  TXD_DATA valid.
- TXD_READY  in  1  engine accepts TXD_DATA.
- TXD_LAST  out  1  final byte of the packet.
- TXD_DATA  out  8  packet byte after the PID.

Behaviour:
- Reset, asynchronous on ULPIRSTB low: all outputs 0, state IDLE, CRC and counter cleared. Reset mid-packet drops TXD_REQ immediately and emits no COMP.
- PID classes:
  - token-AE: 0001 OUT, 1001 IN, 1101 SETUP, 0100 PING;
  - SOF: 0101;
  - data: 0011, 1011, 0111, 1111;
  - handshake: 0010, 1010, 1110, 0110;
  - illegal: 0000, 1000, 1100.
- Beat transfer rule: a TXD beat transfers when TXD_VALID & TXD_READY. TXD_DATA/TXD_LAST are stable while TXD_VALID is high and not ready.
- States: IDLE, TOK1, TOK2, DATA, CRCL, CRCH, WAITACK.
- IDLE, start: PKT_TX_START & !PKT_TX_COMP is required to start.
  - Illegal PID, or data PID with PKT_TX_NUM > MAX_PKT: next cycle COMP=1, ERR=1, TXD_REQ stays 0.
  - Otherwise, next cycle: TXD_REQ=1 and TXD_CPD={2'b00,PID}.
- IDLE, first beat and next state by class:
  - token-AE: TXD_DATA={EPN[0],ADR}, TXD_VALID=1, go to TOK1.
  - SOF: TXD_DATA=FMN[7:0], TXD_VALID=1, go to TOK1.
  - handshake: no beats, go to WAITACK.
  - data: load counter=NUM, CRC16=16'hFFFF, go to DATA.
- TOK1: on transfer, TXD_DATA={~crc5, field[10:3... i.e. bits 10:8]}, arranged as TXD_DATA[7:3]=~CRC5 (x^4 coefficient in bit 3) and TXD_DATA[2:0]=field[10:8]. TXD_LAST=1, go to TOK2.
  - field = {EPN,ADR} for token-AE, FMN for SOF.
  - CRC5: x^5+x^2+1, init 5'h1F, 11 bits processed LSB first.
- TOK2: on transfer, TXD_VALID=0, TXD_LAST=0, go to WAITACK.
- DATA:
  - PKT_TX_DAT_READY = (counter!=0) & (!TXD_VALID | TXD_READY).
  - On VALID&READY: register the byte into TXD_DATA, TXD_VALID=1, update CRC16, decrement counter.
  - Bubbles on PKT_TX_DAT_VALID deassert TXD_VALID; no data is lost.
  - When counter==0 and the output slot is free, load CRCL.
  - NUM=0 goes directly to CRCL.
- CRC16: x^16+x^15+x^2+1, init 16'hFFFF, bytes processed LSB first. Transmitted value is the complement.
- CRCL: drive TXD_DATA = complemented CRC bits 7:0.
- CRCH: drive TXD_DATA = complemented CRC bits 15:8, with TXD_LAST=1. After it transfers, TXD_VALID=0, go to WAITACK.
- WAITACK: on TXD_ACK, TXD_REQ=0, COMP=1, ERR=0, go to IDLE. TXD_ACK outside WAITACK is ignored.
- Abort: PKT_TX_ABORT in any non-IDLE state has priority over all other events in that cycle. Next cycle: TXD_REQ, TXD_VALID, TXD_LAST and DAT_READY = 0; COMP=1, ERR=1; go to IDLE.
- Back-to-back: START held high is not re-accepted on the COMP cycle. Minimum gap is one cycle.
- TXD_CPD holds its value until the next accepted start.

Test Plan:
- SETUP (1101), ADR=0, EPN=0, TXD_READY=1 → TXD_CPD=0x0D; beats 0x00 then 0x10 with LAST on the second beat; TXD_ACK → one-cycle COMP, ERR=0.
- DATA0 (0011), NUM=0 → TXD_CPD=0x03; beats 0x00, 0x00 (LAST); no DAT_READY pulse.
- DATA1, NUM=MAX_PKT, random payload, random TXD_READY/DAT_VALID stalls → byte order and count exact; CRC16 matches the bench model; DAT_READY pulses exactly MAX_PKT times.
- ACK (0010) → TXD_REQ with CPD=0x02, zero TXD_VALID beats, COMP on TXD_ACK. PID 0000, and DATA0 with NUM=MAX_PKT+1 → COMP=ERR=1, TXD_REQ never asserted.
- SOF, FMN=0x7FF and 0x000 → second-byte CRC5 matches the model; FMN[10:8] lands in TXD_DATA[2:0].
- PKT_TX_ABORT asserted during DATA byte 5, then ULPIRSTB low during TOK1 of a later packet → abort gives COMP=ERR=1 with all TXD outputs 0 next cycle; reset clears all outputs asynchronously with no COMP.

Source files
------------

// File: rtl/sc_ulpi_pktgen.sv
// sc_ulpi_pktgen: USB packet generator for the ULPI transmit path.
// Turns a transaction-layer request (PID plus address/endpoint, frame number
// or streamed payload) into the byte sequence that follows the PID on ULPI:
// tokens get a CRC5, data packets get a CRC16, and handshakes carry no bytes.
// Ports:
//   ULPICLK, ULPIRSTB          clock, asynchronous active-low reset
//   PKT_TX_START/ABORT         request a packet / abort the current one
//   PKT_TX_COMP/ERR            completion pulse, with error flag
//   PKT_TX_PID/ADR/EPN/FMN/NUM packet description
//   PKT_TX_DAT/_VALID/_READY   payload byte stream (READY is combinational)
//   TXD_REQ/ACK/CPD            packet request to the protocol engine
//   TXD_VALID/READY/LAST/DATA  byte stream to the protocol engine
module sc_ulpi_pktgen #(
  parameter int unsigned MAX_PKT = 1024,
  parameter int unsigned LEN_W   = 11
) (
  input  logic             ULPICLK,
  input  logic             ULPIRSTB,
  input  logic             PKT_TX_START,
  input  logic             PKT_TX_ABORT,
  output logic             PKT_TX_COMP,
  output logic             PKT_TX_ERR,
  input  logic [3:0]       PKT_TX_PID,
  input  logic [6:0]       PKT_TX_ADR,
  input  logic [3:0]       PKT_TX_EPN,
  input  logic [10:0]      PKT_TX_FMN,
  input  logic [LEN_W-1:0] PKT_TX_NUM,
  input  logic [7:0]       PKT_TX_DAT,
  input  logic             PKT_TX_DAT_VALID,
  output logic             PKT_TX_DAT_READY,
  output logic             TXD_REQ,
  input  logic             TXD_ACK,
  output logic [5:0]       TXD_CPD,
  output logic             TXD_VALID,
  input  logic             TXD_READY,
  output logic             TXD_LAST,
  output logic [7:0]       TXD_DATA
);

  localparam logic [LEN_W-1:0] MAX_NUM = LEN_W'(MAX_PKT);

  typedef enum logic [2:0] {
    S_IDLE, S_TOK1, S_TOK2, S_DATA, S_CRCL, S_CRCH, S_WAITACK
  } state_t;

  typedef enum logic [1:0] {C_TOKEN, C_SOF, C_DATA, C_HSK} pid_class_t;

  // CRCs are kept bit-reflected: bit 0 holds the highest-order coefficient,
  // so the complemented register is already in USB wire order.
  function automatic logic [4:0] crc5_field(input logic [10:0] field);
    logic [4:0] r;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (r[0] ^ field[i]) r = (r >> 1) ^ 5'b10100;
      else                 r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       tok_q, tok_d;
  logic             req_q, req_d;
  logic [5:0]       cpd_q, cpd_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [7:0]       data_q, data_d;
  logic             comp_q, comp_d;
  logic             err_q, err_d;

  pid_class_t  pid_class;
  logic        pid_legal;
  logic [10:0] tok_field;
  logic [4:0]  tok_crc;
  logic        beat_done;
  logic        slot_free;
  logic        dat_ready;

  // PID classification
  always_comb begin
    pid_class = C_HSK;
    pid_legal = 1'b1;
    case (PKT_TX_PID)
      4'b0001, 4'b1001, 4'b1101, 4'b0100: pid_class = C_TOKEN;
      4'b0101:                            pid_class = C_SOF;
      4'b0011, 4'b1011, 4'b0111, 4'b1111: pid_class = C_DATA;
      4'b0010, 4'b1010, 4'b1110, 4'b0110: pid_class = C_HSK;
      default:                            pid_legal = 1'b0;
    endcase
  end

  assign tok_field = (pid_class == C_SOF) ? PKT_TX_FMN : {PKT_TX_EPN, PKT_TX_ADR};
  assign tok_crc   = crc5_field(tok_field);
  assign beat_done = valid_q & TXD_READY;
  assign slot_free = ~valid_q | TXD_READY;
  // An abort in the same cycle wins, so the byte is not taken then.
  assign dat_ready = (state_q == S_DATA) && (cnt_q != '0) && slot_free && !PKT_TX_ABORT;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    tok_d   = tok_q;
    req_d   = req_q;
    cpd_d   = cpd_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    comp_d  = 1'b0;
    err_d   = 1'b0;

    if (PKT_TX_ABORT && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      data_d  = 8'h00;
      comp_d  = 1'b1;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The COMP cycle blocks a held START, giving a one-cycle gap.
          if (PKT_TX_START && !comp_q) begin
            if (!pid_legal || ((pid_class == C_DATA) && (PKT_TX_NUM > MAX_NUM))) begin
              comp_d = 1'b1;
              err_d  = 1'b1;
            end else begin
              req_d = 1'b1;
              cpd_d = {2'b00, PKT_TX_PID};
              case (pid_class)
                C_TOKEN, C_SOF: begin
                  data_d  = tok_field[7:0];
                  valid_d = 1'b1;
                  last_d  = 1'b0;
                  tok_d   = {~tok_crc, tok_field[10:8]};
                  state_d = S_TOK1;
                end
                C_DATA: begin
                  cnt_d   = PKT_TX_NUM;
                  crc_d   = 16'hFFFF;
                  state_d = S_DATA;
                end
                default: state_d = S_WAITACK;
              endcase
            end
          end
        end
        S_TOK1: begin
          if (beat_done) begin
            data_d  = tok_q;
            last_d  = 1'b1;
            state_d = S_TOK2;
          end
        end
        S_TOK2: begin
          if (beat_done) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_WAITACK;
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            if (slot_free) begin
              data_d  = ~crc_q[7:0];
              valid_d = 1'b1;
              state_d = S_CRCL;
            end
          end else if (dat_ready && PKT_TX_DAT_VALID) begin
            data_d  = PKT_TX_DAT;
            valid_d = 1'b1;
            crc_d   = crc16_byte(crc_q, PKT_TX_DAT);
            cnt_d   = cnt_q - LEN_W'(1);
          end else if (beat_done) begin
            // payload bubble: nothing new to present
            valid_d = 1'b0;
          end
        end
        S_CRCL: begin
          if (beat_done) begin
            data_d  = ~crc_q[15:8];
            last_d  = 1'b1;
            state_d = S_CRCH;
          end
        end
        S_CRCH: begin
          if (beat_done) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_WAITACK;
          end
        end
        S_WAITACK: begin
          if (TXD_ACK) begin
            req_d   = 1'b0;
            comp_d  = 1'b1;
            err_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
    if (!ULPIRSTB) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      crc_q   <= '0;
      tok_q   <= '0;
      req_q   <= 1'b0;
      cpd_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      comp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      tok_q   <= tok_d;
      req_q   <= req_d;
      cpd_q   <= cpd_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      comp_q  <= comp_d;
      err_q   <= err_d;
    end
  end

  assign PKT_TX_COMP      = comp_q;
  assign PKT_TX_ERR       = err_q;
  assign PKT_TX_DAT_READY = dat_ready;
  assign TXD_REQ          = req_q;
  assign TXD_CPD          = cpd_q;
  assign TXD_VALID        = valid_q;
  assign TXD_LAST         = last_q;
  assign TXD_DATA         = data_q;

endmodule

// File: tb/tb_sc_ulpi_pktgen.sv
// tb_sc_ulpi_pktgen: scoreboard bench for sc_ulpi_pktgen. Stimulus pushes the
// expected bytes / CPD / completion status; a negedge monitor pops and
// compares whenever the DUT presents a beat, a request or a completion.
module tb_sc_ulpi_pktgen;

  localparam int MAX_PKT = 1024;
  localparam int LEN_W   = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, abort = 1'b0;
  logic             comp, err;
  logic [3:0]       pid = '0;
  logic [6:0]       adr = '0;
  logic [3:0]       epn = '0;
  logic [10:0]      fmn = '0;
  logic [LEN_W-1:0] num = '0;
  logic [7:0]       dat = '0;
  logic             dat_valid = 1'b0;
  logic             dat_ready;
  logic             txd_req, txd_ack = 1'b0;
  logic [5:0]       txd_cpd;
  logic             txd_valid, txd_ready = 1'b1, txd_last;
  logic [7:0]       txd_data;

  sc_ulpi_pktgen #(.MAX_PKT(MAX_PKT), .LEN_W(LEN_W)) dut (
    .ULPICLK(clk), .ULPIRSTB(rst_n),
    .PKT_TX_START(start), .PKT_TX_ABORT(abort),
    .PKT_TX_COMP(comp), .PKT_TX_ERR(err),
    .PKT_TX_PID(pid), .PKT_TX_ADR(adr), .PKT_TX_EPN(epn), .PKT_TX_FMN(fmn),
    .PKT_TX_NUM(num), .PKT_TX_DAT(dat), .PKT_TX_DAT_VALID(dat_valid),
    .PKT_TX_DAT_READY(dat_ready),
    .TXD_REQ(txd_req), .TXD_ACK(txd_ack), .TXD_CPD(txd_cpd),
    .TXD_VALID(txd_valid), .TXD_READY(txd_ready), .TXD_LAST(txd_last),
    .TXD_DATA(txd_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] exp_beat[$];   // {last, data}
  logic [5:0] exp_cpd[$];
  logic       exp_err[$];
  bit         wire_q[$];     // wire-order bits after the PID
  logic [7:0] pay[$];

  int hs_count = 0;
  int comp_count = 0;
  int req_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 token, 1 SOF, 2 data, 3 handshake, 4 illegal
  function automatic int pid_class(input logic [3:0] p);
    case (p)
      4'h1, 4'h9, 4'hD, 4'h4: return 0;
      4'h5:                   return 1;
      4'h3, 4'hB, 4'h7, 4'hF: return 2;
      4'h2, 4'hA, 4'hE, 4'h6: return 3;
      default:                return 4;
    endcase
  endfunction

  // Plain polynomial CRC over the first n wire bits, highest coefficient at bit w-1.
  function automatic logic [15:0] crc_msb(input int n, input int w, input logic [15:0] poly,
                                          input logic [15:0] init);
    logic [15:0] c;
    logic        fb;
    c = init;
    for (int i = 0; i < n; i++) begin
      fb = c[w-1] ^ wire_q[i];
      c  = c << 1;
      if (fb) c = c ^ poly;
    end
    return c & ((16'h1 << w) - 16'h1);
  endfunction

  // Build the wire bitstream after the PID and slice it into expected beats.
  task automatic model_pkt(input int cls, input logic [6:0] a, input logic [3:0] e,
                           input logic [10:0] f);
    logic [10:0] field;
    logic [15:0] c;
    logic [7:0]  b;
    int          nb;
    wire_q.delete();
    if (cls == 0 || cls == 1) begin
      field = (cls == 1) ? f : {e, a};
      for (int i = 0; i < 11; i++) wire_q.push_back(field[i]);
      c = crc_msb(11, 5, 16'h0005, 16'h001F);
      for (int i = 4; i >= 0; i--) wire_q.push_back(~c[i]);
    end else if (cls == 2) begin
      foreach (pay[k]) for (int j = 0; j < 8; j++) wire_q.push_back(pay[k][j]);
      c = crc_msb(wire_q.size(), 16, 16'h8005, 16'hFFFF);
      for (int i = 15; i >= 0; i--) wire_q.push_back(~c[i]);
    end
    nb = wire_q.size() / 8;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 8; j++) b[j] = wire_q[k*8 + j];
      exp_beat.push_back({(k == nb - 1), b});
    end
  endtask

  // Monitor / scoreboard
  logic       req_prev = 1'b0;
  logic       stall_prev = 1'b0;
  logic       abort_prev = 1'b0;
  logic [8:0] beat_prev = '0;
  logic [8:0] eb;
  always @(negedge clk) begin
    if (rst_n) begin
      if (txd_req && !req_prev) begin
        req_count++;
        if (exp_cpd.size() == 0) check("unexpected_req", 1, 0);
        else check("cpd", 32'(txd_cpd), 32'(exp_cpd.pop_front()));
      end
      req_prev = txd_req;
      if (stall_prev && !abort_prev)
        check("hold_beat", {22'h0, txd_valid, txd_last, txd_data}, {22'h0, 1'b1, beat_prev});
      stall_prev = txd_valid && !txd_ready;
      beat_prev  = {txd_last, txd_data};
      abort_prev = abort;
      if (txd_valid && txd_ready) begin
        if (exp_beat.size() == 0) check("unexpected_beat", 32'(txd_data), 32'h1FF);
        else begin
          eb = exp_beat.pop_front();
          check("beat", {23'h0, txd_last, txd_data}, {23'h0, eb});
        end
      end
      if (dat_ready && dat_valid) hs_count++;
      if (comp) begin
        comp_count++;
        if (exp_err.size() == 0) check("unexpected_comp", 1, 0);
        else check("comp_err", 32'(err), 32'(exp_err.pop_front()));
        check("comp_idle", {28'h0, txd_req, txd_valid, txd_last, dat_ready}, 32'h0);
      end
    end else begin
      req_prev   = 1'b0;
      stall_prev = 1'b0;
    end
  end

  task automatic run_pkt(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                         input logic [10:0] f, input int n, input bit stall, input int abort_at);
    int cls, hs0, rq0, c0, budget, got;
    bit rej, abort_done;
    cls = pid_class(p);
    rej = (cls == 4) || (cls == 2 && n > MAX_PKT);
    pay.delete();
    if (cls == 2 && !rej) for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    if (rej) exp_err.push_back(1'b1);
    else begin
      exp_cpd.push_back({2'b00, p});
      model_pkt(cls, a, e, f);
      exp_err.push_back(abort_at >= 0);
    end
    hs0 = hs_count; rq0 = req_count; c0 = comp_count;
    abort_done = 0; budget = 0;
    @(posedge clk); #1;
    start = 1'b1; pid = p; adr = a; epn = e; fmn = f; num = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    while (comp_count == c0 && budget < 20000) begin
      got = hs_count - hs0;
      txd_ready = stall ? ($urandom_range(3) != 0) : 1'b1;
      if (got < pay.size()) begin
        dat = pay[got];
        dat_valid = stall ? ($urandom_range(2) != 0) : 1'b1;
      end else dat_valid = 1'b0;
      abort = (abort_at >= 0) && (got == abort_at) && !abort_done;
      if (abort) abort_done = 1;
      txd_ack = txd_req && (exp_beat.size() == 0) && !txd_valid && ($urandom_range(1) == 1);
      @(posedge clk); #1;
      budget++;
    end
    abort = 1'b0; txd_ack = 1'b0; dat_valid = 1'b0; txd_ready = 1'b1;
    if (budget >= 20000) check("timeout", 1, 0);
    if (rej) check("no_req_on_reject", 32'(req_count - rq0), 0);
    else if (abort_at >= 0) exp_beat.delete();
    else begin
      check("beats_left", 32'(exp_beat.size()), 0);
      if (cls == 2) check("dat_ready_count", 32'(hs_count - hs0), 32'(n));
    end
  endtask

  logic [3:0] legal_pid [12];
  int c0, n;

  initial begin
    legal_pid = '{4'h1, 4'h9, 4'hD, 4'h4, 4'h5, 4'h3, 4'hB, 4'h7, 4'hF, 4'h2, 4'hA, 4'hE};
    #1;
    check("rst_outputs", {15'h0, txd_req, txd_valid, txd_last, comp, err, dat_ready, txd_cpd, txd_data}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_pkt(4'hD, 7'h00, 4'h0, 11'h000, 0, 0, -1);             // SETUP addr 0 / ep 0
    run_pkt(4'h3, 7'h00, 4'h0, 11'h000, 0, 0, -1);             // DATA0, empty
    run_pkt(4'hB, 7'h00, 4'h0, 11'h000, MAX_PKT, 1, -1);       // DATA1, full size, stalls
    run_pkt(4'h2, 7'h00, 4'h0, 11'h000, 0, 1, -1);             // ACK
    run_pkt(4'h0, 7'h12, 4'h3, 11'h000, 0, 0, -1);             // illegal PID
    run_pkt(4'h3, 7'h00, 4'h0, 11'h000, MAX_PKT + 1, 0, -1);   // oversize data
    run_pkt(4'h5, 7'h00, 4'h0, 11'h7FF, 0, 0, -1);             // SOF all ones
    run_pkt(4'h5, 7'h00, 4'h0, 11'h000, 0, 1, -1);             // SOF zero
    for (int k = 0; k < 20; k++)
      run_pkt(legal_pid[$urandom_range(11)], 7'($urandom), 4'($urandom), 11'($urandom),
              $urandom_range(40), 1, -1);

    // START held high: accepted, blocked on COMP, accepted again
    exp_err.push_back(1'b1); exp_err.push_back(1'b1);
    c0 = comp_count;
    @(posedge clk); #1 start = 1'b1; pid = 4'h8;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("held_start_comps", 32'(comp_count - c0), 2);

    run_pkt(4'h3, 7'h00, 4'h0, 11'h000, 20, 0, 5);             // abort at byte 5

    // Reset while the first token byte waits for TXD_READY
    c0 = comp_count;
    exp_cpd.push_back(6'h05);
    txd_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1; pid = 4'h5; fmn = 11'h2A5;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!txd_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) check("tok1_timeout", 1, 0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", {15'h0, txd_req, txd_valid, txd_last, comp, err, dat_ready, txd_cpd, txd_data}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; txd_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("no_comp_after_reset", 32'(comp_count - c0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
